// File: rtl/rr_mux5_2_arbiter_pkg.sv
// rr_arb_pkg: shared constants, output-register state and channel rotation helper
package rr_arb_pkg;
  localparam int N_CHAN = 5;
  localparam int DATA_W = 2;
  localparam int SEL_W = 3;
  typedef enum logic {EMPTY, FULL} out_state_t;
  function automatic logic [SEL_W-1:0] next_chan(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(N_CHAN - 1)) ? '0 : idx + SEL_W'(1);
  endfunction
endpackage

// File: rtl/rr_mux5_2_arbiter_if.sv
// rr_mux5_2_arbiter_if: producer request/grant bus plus downstream valid/ready port
interface rr_mux5_2_arbiter_if;
  import rr_arb_pkg::*;
  logic [N_CHAN-1:0] in_valid;
  logic [N_CHAN*DATA_W-1:0] in_data;
  logic [N_CHAN-1:0] in_ready;
  logic out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0] out_chan;
  logic out_ready;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_chan);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_chan);
endinterface

// File: rtl/rr_mux5_2_arbiter_mux.sv
// mux5_2: 5-way 2-bit word select; select codes 5-7 read zero padding
module mux5_2
  import rr_arb_pkg::*;
(
  input  logic [N_CHAN*DATA_W-1:0] a,
  input  logic [SEL_W-1:0]         s,
  output logic [DATA_W-1:0]        y
);
  logic [(1<<SEL_W)*DATA_W-1:0] pad;
  assign pad = {{((1<<SEL_W)-N_CHAN)*DATA_W{1'b0}}, a};
  assign y = pad[s*DATA_W +: DATA_W];
endmodule

// File: rtl/rr_mux5_2_arbiter.sv
// rr_mux5_2_arbiter: round-robin grant over five channels into a one-deep output register
module rr_mux5_2_arbiter
  import rr_arb_pkg::*;
(
  input logic clk,
  input logic rst,
  rr_mux5_2_arbiter_if.slave bus
);
  out_state_t state_q, state_d;
  logic [SEL_W-1:0] last_grant_q, grant_idx, cand;
  logic [DATA_W-1:0] out_data_q, y;
  logic [SEL_W-1:0] out_chan_q;
  logic found, can_load, accept, drain;
  // search starts just after last_grant so it is visited last
  always_comb begin
    grant_idx = last_grant_q;
    found = 1'b0;
    cand = last_grant_q;
    for (int k = 0; k < N_CHAN; k++) begin
      cand = next_chan(cand);
      if (!found && bus.in_valid[cand]) begin
        grant_idx = cand;
        found = 1'b1;
      end
    end
  end
  assign drain = (state_q == FULL) && bus.out_ready;
  assign can_load = (state_q == EMPTY) || drain;
  assign accept = !rst && can_load && found;
  assign state_d = accept ? FULL : drain ? EMPTY : state_q;
  assign bus.in_ready = accept ? N_CHAN'(1) << grant_idx : '0;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data = out_data_q;
  assign bus.out_chan = out_chan_q;
  mux5_2 u_mux (.a(bus.in_data), .s(grant_idx), .y(y));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      last_grant_q <= SEL_W'(N_CHAN - 1);
      out_data_q <= '0;
      out_chan_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_data_q <= y;
        out_chan_q <= grant_idx;
        last_grant_q <= grant_idx;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux5_2_arbiter.sv
// tb_rr_mux5_2_arbiter: directed vectors with hand-computed grants and output words
module tb_rr_mux5_2_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  rr_mux5_2_arbiter_if bus();
  rr_mux5_2_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic out_chk(input string tag, input logic v, input logic [1:0] d, input logic [2:0] c);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
    chk({tag, "_chan"}, 32'(bus.out_chan), 32'(c));
  endtask
  logic [2:0] ord [6] = '{0, 1, 2, 3, 4, 0};
  logic [1:0] dat [6] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
  initial begin
    bus.in_valid = 5'b11111;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    tick();
    tick();
    out_chk("rst", 0, 0, 0);
    rst = 1'b0;
    bus.in_valid = 5'b00100;
    bus.in_data = 10'b00_00_11_00_00;
    bus.out_ready = 1'b1;
    #1;
    chk("single_grant", 32'(bus.in_ready), 32'b00100);
    tick();
    out_chk("single", 1, 2'b11, 2);
    bus.in_valid = '0;
    bus.in_data = 10'b11_10_01_00_11;
    #1;
    chk("drain_in_ready", 32'(bus.in_ready), 0);
    tick();
    out_chk("drain", 0, 2'b11, 2);
    bus.in_valid = 5'b11111;
    #1;
    chk("after_drain_grant", 32'(bus.in_ready), 32'b01000);
    tick();
    out_chk("after_drain", 1, 2'b10, 3);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 0);
    tick();
    rst = 1'b0;
    out_chk("midrst", 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_grant%0d", i), 32'(bus.in_ready), 32'(5'b1 << ord[i]));
      tick();
      out_chk($sformatf("rr%0d", i), 1, dat[i], ord[i]);
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_ready%0d", i), 32'(bus.in_ready), 0);
      tick();
      out_chk($sformatf("stall%0d", i), 1, 2'b11, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_grant", 32'(bus.in_ready), 32'b00010);
    tick();
    out_chk("release", 1, 2'b00, 1);
    bus.in_valid = 5'b01000;
    tick();
    out_chk("set_last3", 1, 2'b10, 3);
    bus.in_valid = 5'b01001;
    #1;
    chk("wrap_grant", 32'(bus.in_ready), 32'b00001);
    tick();
    out_chk("wrap", 1, 2'b11, 0);
    #1;
    chk("fair_grant", 32'(bus.in_ready), 32'b01000);
    tick();
    out_chk("fair", 1, 2'b10, 3);
    bus.in_valid = 5'b01000;
    #1;
    chk("only_last_grant", 32'(bus.in_ready), 32'b01000);
    tick();
    out_chk("only_last", 1, 2'b10, 3);
    bus.in_valid = '0;
    tick();
    out_chk("final_drain", 0, 2'b10, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
